// File: rtl/dht11_sequencer.sv
// DHT11 single-wire read sequencer: host start pulse, sensor handshake,
// 40-bit pulse-width capture, checksum check and re-read holdoff.
module dht11_sequencer #(
    parameter int T_START   = 1_800_000,
    parameter int T_TIMEOUT = 20_000,
    parameter int T_BIT_THR = 5_000,
    parameter int T_HOLDOFF = 100_000_000,
    parameter int CNT_W     = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwr_ok,
    input  logic       req,
    input  logic       dq_in,
    output logic       dq_oe,
    output logic       busy,
    output logic       valid,
    output logic       err,
    output logic [1:0] err_code,
    output logic [7:0] hum_int,
    output logic [7:0] hum_dec,
    output logic [7:0] tmp_int,
    output logic [7:0] tmp_dec,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_REL   = 4'd2,
        S_RSP_L = 4'd3,
        S_RSP_H = 4'd4,
        S_BIT_L = 4'd5,
        S_BIT_H = 4'd6,
        S_CHECK = 4'd7,
        S_FAIL  = 4'd8,
        S_HOLD  = 4'd9
    } state_t;

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(T_START - 1);
    localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(T_TIMEOUT);
    localparam logic [CNT_W-1:0] BIT_THR    = CNT_W'(T_BIT_THR);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLDOFF - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             dq_s1, dqs, dqs_prev;
    logic             dq_fall, dq_rise;
    logic [39:0]      shreg;
    logic [5:0]       bit_idx;
    logic [1:0]       fail_code, fail_code_next;
    logic [9:0]       sum;
    logic             sum_ok;

    assign dq_fall   = dqs_prev & ~dqs;
    assign dq_rise   = ~dqs_prev & dqs;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    assign sum = 10'(shreg[39:32]) + 10'(shreg[31:24]) + 10'(shreg[23:16]) + 10'(shreg[15:8]);
    assign sum_ok = (sum[7:0] == shreg[7:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            fail_code <= 2'd0;
        end else begin
            state     <= state_next;
            fail_code <= fail_code_next;
            // Phase counter measures time spent in the current state only.
            if (state_next != state)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_next     = state;
        fail_code_next = fail_code;
        case (state)
            S_IDLE:  if (req && pwr_ok) state_next = S_START;
            S_START: if (cnt == START_LAST) state_next = S_REL;
            S_REL: begin
                if (dq_fall) state_next = S_RSP_L;
                else if (cnt == TIMEOUT) begin state_next = S_FAIL; fail_code_next = 2'd1; end
            end
            S_RSP_L: begin
                if (dq_rise) state_next = S_RSP_H;
                else if (cnt == TIMEOUT) begin state_next = S_FAIL; fail_code_next = 2'd1; end
            end
            S_RSP_H: begin
                if (dq_fall) state_next = S_BIT_L;
                else if (cnt == TIMEOUT) begin state_next = S_FAIL; fail_code_next = 2'd1; end
            end
            S_BIT_L: begin
                if (dq_rise) state_next = S_BIT_H;
                else if (cnt == TIMEOUT) begin state_next = S_FAIL; fail_code_next = 2'd2; end
            end
            S_BIT_H: begin
                if (dq_fall) state_next = (bit_idx == 6'd39) ? S_CHECK : S_BIT_L;
                else if (cnt == TIMEOUT) begin state_next = S_FAIL; fail_code_next = 2'd2; end
            end
            S_CHECK: state_next = S_HOLD;
            S_FAIL:  state_next = S_HOLD;
            S_HOLD:  if (cnt == HOLD_LAST) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dq_s1    <= 1'b1;
            dqs      <= 1'b1;
            dqs_prev <= 1'b1;
            dq_oe    <= 1'b0;
            valid    <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
            shreg    <= '0;
            bit_idx  <= '0;
            hum_int  <= '0;
            hum_dec  <= '0;
            tmp_int  <= '0;
            tmp_dec  <= '0;
        end else begin
            dq_s1    <= dq_in;
            dqs      <= dq_s1;
            dqs_prev <= dqs;
            dq_oe    <= (state_next == S_START);
            valid    <= 1'b0;
            err      <= 1'b0;
            if (state_next == S_START && state != S_START) begin
                shreg   <= '0;
                bit_idx <= '0;
            end
            // Bit value is decided by how long the line stayed high.
            if (state == S_BIT_H && dq_fall) begin
                shreg   <= {shreg[38:0], (cnt > BIT_THR)};
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == S_CHECK) begin
                if (sum_ok) begin
                    hum_int  <= shreg[39:32];
                    hum_dec  <= shreg[31:24];
                    tmp_int  <= shreg[23:16];
                    tmp_dec  <= shreg[15:8];
                    valid    <= 1'b1;
                    err_code <= 2'd0;
                end else begin
                    err      <= 1'b1;
                    err_code <= 2'd3;
                end
            end
            if (state == S_FAIL) begin
                err      <= 1'b1;
                err_code <= fail_code;
            end
        end
    end

endmodule

// File: tb/tb_dht11_sequencer.sv
// Directed bench for dht11_sequencer with a wired-AND DQ bus and a timed
// sensor model (high 10 cycles = 0, high 30 cycles = 1).
module tb_dht11_sequencer;

    localparam int T_START   = 100;
    localparam int T_TIMEOUT = 50;
    localparam int T_BIT_THR = 20;
    localparam int T_HOLDOFF = 200;
    localparam logic [3:0] ST_BIT_H = 4'd6;

    logic       clk = 1'b0;
    logic       rst, pwr_ok, req, sensor_low;
    logic       dq_in;
    logic       dq_oe, busy, valid, err;
    logic [1:0] err_code;
    logic [7:0] hum_int, hum_dec, tmp_int, tmp_dec;
    logic [3:0] state_dbg;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Open-drain bus: either side pulling low wins, otherwise pulled up.
    assign dq_in = ~(dq_oe | sensor_low);

    always #5 clk = ~clk;

    dht11_sequencer #(
        .T_START(T_START), .T_TIMEOUT(T_TIMEOUT), .T_BIT_THR(T_BIT_THR),
        .T_HOLDOFF(T_HOLDOFF), .CNT_W(27)
    ) dut (
        .clk(clk), .rst(rst), .pwr_ok(pwr_ok), .req(req), .dq_in(dq_in),
        .dq_oe(dq_oe), .busy(busy), .valid(valid), .err(err), .err_code(err_code),
        .hum_int(hum_int), .hum_dec(hum_dec), .tmp_int(tmp_int), .tmp_dec(tmp_dec),
        .state_dbg(state_dbg)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req();
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    // Sensor side: answers the host start pulse and sends nbits of frame.
    task automatic sensor_drive(input logic [39:0] frame, input int nbits,
                                input bit hang_low, output int start_len);
        int guard;
        guard = 0;
        start_len = 0;
        while (dq_oe !== 1'b1 && guard < 1000) begin @(negedge clk); guard++; end
        while (dq_oe !== 1'b0 && guard < 1000) begin @(negedge clk); guard++; start_len++; end
        chk_cnt++;
        if (guard >= 1000) $display("FAIL sensor_wait_release: waited %0d cycles, limit 1000", guard);
        else pass_cnt++;
        step(5);
        sensor_low = 1'b1; step(20);
        sensor_low = 1'b0; step(20);
        for (int i = 0; i < nbits; i++) begin
            sensor_low = 1'b1; step(12);
            sensor_low = 1'b0; step(frame[39-i] ? 30 : 10);
        end
        sensor_low = 1'b1;
        if (!hang_low) begin
            step(12);
            sensor_low = 1'b0;
        end
    endtask

    task automatic wait_result(input int budget, output bit got_v, output bit got_e);
        got_v = 1'b0;
        got_e = 1'b0;
        for (int i = 0; i < budget && !got_v && !got_e; i++) begin
            @(negedge clk);
            if (valid === 1'b1) got_v = 1'b1;
            if (err === 1'b1) got_e = 1'b1;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL %s_idle: busy=%b after %0d cycles, want 0", name, busy, n);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; pwr_ok = 1'b0; req = 1'b0; sensor_low = 1'b0;
        step(3);
        chk_cnt++; if (dq_oe !== 1'b0) $display("FAIL reset_dq_oe: got %b want 0", dq_oe); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (valid !== 1'b0 || err !== 1'b0)
            $display("FAIL reset_pulses: valid=%b err=%b want 0 0", valid, err); else pass_cnt++;
        chk_cnt++; if (err_code !== 2'd0) $display("FAIL reset_err_code: got %0d want 0", err_code); else pass_cnt++;
        chk_cnt++; if ({hum_int, hum_dec, tmp_int, tmp_dec} !== 32'h0)
            $display("FAIL reset_data: got %h want 00000000", {hum_int, hum_dec, tmp_int, tmp_dec}); else pass_cnt++;
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_no_power();
        bit seen_oe, seen_busy;
        seen_oe = 1'b0; seen_busy = 1'b0;
        pwr_ok = 1'b0;
        pulse_req();
        for (int i = 0; i < 300; i++) begin
            if (i == 20) pwr_ok = 1'b1;
            @(negedge clk);
            if (dq_oe === 1'b1) seen_oe = 1'b1;
            if (busy === 1'b1) seen_busy = 1'b1;
        end
        chk_cnt++; if (seen_oe !== 1'b0) $display("FAIL no_power_dq_oe: saw %b want 0", seen_oe); else pass_cnt++;
        chk_cnt++; if (seen_busy !== 1'b0) $display("FAIL no_power_busy: saw %b want 0", seen_busy); else pass_cnt++;
    endtask

    task automatic test_good_read();
        bit v, e;
        int start_len;
        pwr_ok = 1'b1;
        pulse_req();
        fork
            sensor_drive(40'h3700190555, 40, 1'b0, start_len);
            wait_result(5000, v, e);
        join
        chk_cnt++; if (start_len != T_START) $display("FAIL good_start_len: got %0d want %0d", start_len, T_START); else pass_cnt++;
        chk_cnt++; if (v !== 1'b1 || e !== 1'b0) $display("FAIL good_result: valid=%b err=%b want 1 0", v, e); else pass_cnt++;
        chk_cnt++; if (hum_int !== 8'h37) $display("FAIL good_hum_int: got %h want 37", hum_int); else pass_cnt++;
        chk_cnt++; if (hum_dec !== 8'h00) $display("FAIL good_hum_dec: got %h want 00", hum_dec); else pass_cnt++;
        chk_cnt++; if (tmp_int !== 8'h19) $display("FAIL good_tmp_int: got %h want 19", tmp_int); else pass_cnt++;
        chk_cnt++; if (tmp_dec !== 8'h05) $display("FAIL good_tmp_dec: got %h want 05", tmp_dec); else pass_cnt++;
        chk_cnt++; if (err_code !== 2'd0) $display("FAIL good_err_code: got %0d want 0", err_code); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL good_busy_in_hold: got %b want 1", busy); else pass_cnt++;
        wait_idle("good");
    endtask

    task automatic test_bad_checksum();
        bit v, e;
        int start_len;
        pwr_ok = 1'b1;
        pulse_req();
        fork
            sensor_drive(40'h3700190554, 40, 1'b0, start_len);
            wait_result(5000, v, e);
            begin step(200); pwr_ok = 1'b0; end
        join
        chk_cnt++; if (v !== 1'b0 || e !== 1'b1) $display("FAIL cksum_result: valid=%b err=%b want 0 1", v, e); else pass_cnt++;
        chk_cnt++; if (err_code !== 2'd3) $display("FAIL cksum_err_code: got %0d want 3", err_code); else pass_cnt++;
        chk_cnt++; if ({hum_int, hum_dec, tmp_int, tmp_dec} !== 32'h37001905)
            $display("FAIL cksum_data_kept: got %h want 37001905", {hum_int, hum_dec, tmp_int, tmp_dec}); else pass_cnt++;
        wait_idle("cksum");
        pwr_ok = 1'b1;
    endtask

    task automatic test_no_response();
        int n;
        pulse_req();
        n = 0;
        while (dq_oe === 1'b1 && n < 1000) begin @(negedge clk); n++; end
        n = 0;
        while (err !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk_cnt++; if (n < T_TIMEOUT || n > T_TIMEOUT + 4)
            $display("FAIL noresp_latency: err after %0d cycles, want %0d..%0d", n, T_TIMEOUT, T_TIMEOUT + 4); else pass_cnt++;
        chk_cnt++; if (err_code !== 2'd1) $display("FAIL noresp_err_code: got %0d want 1", err_code); else pass_cnt++;
        chk_cnt++; if (hum_int !== 8'h37) $display("FAIL noresp_data_kept: got %h want 37", hum_int); else pass_cnt++;
        wait_idle("noresp");
    endtask

    task automatic test_bit_timeout();
        bit v, e;
        int start_len;
        pulse_req();
        fork
            sensor_drive(40'h3700190555, 12, 1'b1, start_len);
            wait_result(5000, v, e);
        join
        sensor_low = 1'b0;
        chk_cnt++; if (v !== 1'b0 || e !== 1'b1) $display("FAIL bitto_result: valid=%b err=%b want 0 1", v, e); else pass_cnt++;
        chk_cnt++; if (err_code !== 2'd2) $display("FAIL bitto_err_code: got %0d want 2", err_code); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL bitto_busy_in_hold: got %b want 1", busy); else pass_cnt++;
        wait_idle("bitto");
    endtask

    task automatic test_hold_req();
        bit v, e, stray;
        int start_len;
        pulse_req();
        fork
            sensor_drive(40'h41021A0360, 40, 1'b0, start_len);
            wait_result(5000, v, e);
        join
        chk_cnt++; if (v !== 1'b1) $display("FAIL hold_valid: got %b want 1", v); else pass_cnt++;
        chk_cnt++; if ({hum_int, hum_dec, tmp_int, tmp_dec} !== 32'h41021A03)
            $display("FAIL hold_data: got %h want 41021A03", {hum_int, hum_dec, tmp_int, tmp_dec}); else pass_cnt++;
        chk_cnt++; if (err_code !== 2'd0) $display("FAIL hold_err_code_cleared: got %0d want 0", err_code); else pass_cnt++;
        step(10);
        pulse_req();
        wait_idle("hold");
        stray = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === 1'b1 || dq_oe === 1'b1) stray = 1'b1;
        end
        chk_cnt++; if (stray !== 1'b0) $display("FAIL hold_req_ignored: saw start %b want 0", stray); else pass_cnt++;
    endtask

    task automatic test_reset_mid_bit();
        int start_len;
        pulse_req();
        fork
            sensor_drive(40'h3700190555, 40, 1'b0, start_len);
            begin
                int n;
                n = 0;
                while (state_dbg !== ST_BIT_H && n < 3000) begin @(negedge clk); n++; end
                chk_cnt++; if (state_dbg !== ST_BIT_H) $display("FAIL rst_reach_bit_h: state %0d want %0d", state_dbg, ST_BIT_H); else pass_cnt++;
                rst = 1'b1;
                @(negedge clk);
                chk_cnt++; if (dq_oe !== 1'b0 || busy !== 1'b0)
                    $display("FAIL rst_mid_ctrl: dq_oe=%b busy=%b want 0 0", dq_oe, busy); else pass_cnt++;
                chk_cnt++; if ({hum_int, hum_dec, tmp_int, tmp_dec} !== 32'h0)
                    $display("FAIL rst_mid_data: got %h want 00000000", {hum_int, hum_dec, tmp_int, tmp_dec}); else pass_cnt++;
                rst = 1'b0;
            end
        join
        step(5);
    endtask

    initial begin
        test_reset();
        test_no_power();
        test_good_read();
        test_bad_checksum();
        test_no_response();
        test_bit_timeout();
        test_hold_req();
        test_reset_mid_bit();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
